// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: transfer sizes, the data-bus bridge state
// encoding and the memory map region bases used by the address decoders.
package soc_bus_pkg;

    // AHB-style transfer sizes
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_RDW  = 3'd3,
        ST_ERR1 = 3'd4,
        ST_ERR2 = 3'd5
    } bridge_state_t;

    // Memory map region bases
    localparam logic [31:0] MAP_RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MAP_MMIO_BASE = 32'h0001_0000;
    localparam logic [31:0] MAP_ROM_BASE  = 32'h0002_0000;

    // True when a transfer of this size cannot be issued at this address
    function automatic logic is_misaligned(input logic [1:0] adr_lo,
                                           input logic [2:0] size);
        logic bad;
        case (size)
            HSIZE_BYTE: bad = 1'b0;
            HSIZE_HALF: bad = adr_lo[0];
            HSIZE_WORD: bad = (adr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/byte_lane_mask.sv
// Byte-lane write-enable decode for a 32-bit memory word, plus an alignment
// check. Purely combinational; shared with the debugger access path.
module byte_lane_mask
    import soc_bus_pkg::*;
(
    input  logic [1:0] adr_lo,
    input  logic [2:0] hsize,
    output logic [3:0] wren,
    output logic       misalign
);

    // Select the byte lanes touched by the transfer
    always_comb begin
        wren     = 4'b0000;
        misalign = is_misaligned(adr_lo, hsize);
        case (hsize)
            HSIZE_BYTE: wren = 4'b0001 << adr_lo;
            HSIZE_HALF: wren = adr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: wren = 4'b1111;
            default:    wren = 4'b0000;
        endcase
    end

endmodule

// File: rtl/h3_dbus_bridge.sv
// Hazard3 data port (pipelined address/data phase) to simple SoC memory bus.
// The debugger owns the memory bus whenever ext_busy is high; the core side
// simply stalls its data phase until the bus is free. Reads see mem_do one
// cycle after mem_op, so a read spends one extra cycle in RDW.
module h3_dbus_bridge
    import soc_bus_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aph_req,
    output logic              aph_ready,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic [31:0]       wdata,
    output logic              dph_ready,
    output logic              dph_err,
    output logic [31:0]       rdata,
    input  logic              ext_busy,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [3:0]        mem_wren,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_do
);

    // The RDW timing assumes mem_do is valid exactly one cycle after mem_op
    generate
        if (MEM_RD_LAT != 1) begin : g_bad_rd_lat
            $error("h3_dbus_bridge: only MEM_RD_LAT == 1 is supported");
        end
    endgenerate

    bridge_state_t     r_state;
    logic [ADDR_W-1:0] r_adr;
    logic [3:0]        r_wren;
    logic              r_write;

    logic              w_wr_go;
    logic              w_rd_go;
    logic              w_completing;
    logic              w_accept;
    logic [3:0]        w_lane_wren;
    logic              w_misalign;
    bridge_state_t     w_next_xfer;

    // Lane mask and alignment of the address-phase request
    byte_lane_mask u_lane (
        .adr_lo   (haddr[1:0]),
        .hsize    (hsize),
        .wren     (w_lane_wren),
        .misalign (w_misalign)
    );

    // Handshake decode: issue, completion and address-phase accept
    always_comb begin
        w_wr_go      = (r_state == ST_WR) & ~ext_busy;
        w_rd_go      = (r_state == ST_RD) & ~ext_busy;
        w_completing = w_wr_go | (r_state == ST_RDW) | (r_state == ST_ERR2);
        w_accept     = aph_req & ~reset & ((r_state == ST_IDLE) | w_completing);
        if (w_misalign) begin
            w_next_xfer = ST_ERR1;
        end else if (hwrite) begin
            w_next_xfer = ST_WR;
        end else begin
            w_next_xfer = ST_RD;
        end
    end

    // Output decode from state; address/data buses are zero unless selected
    always_comb begin
        aph_ready = w_accept;
        dph_ready = w_completing;
        dph_err   = 1'b0;
        rdata     = 32'h0000_0000;
        mem_op    = 1'b0;
        mem_adr   = {ADDR_W{1'b0}};
        mem_wren  = 4'b0000;
        mem_di    = 32'h0000_0000;
        case (r_state)
            ST_WR: begin
                if (w_wr_go) begin
                    mem_op   = 1'b1;
                    mem_adr  = r_adr;
                    mem_wren = r_write ? r_wren : 4'b0000;
                    mem_di   = wdata;
                end else begin
                    mem_op   = 1'b0;
                end
            end
            ST_RD: begin
                if (w_rd_go) begin
                    mem_op  = 1'b1;
                    mem_adr = r_adr;
                end else begin
                    mem_op  = 1'b0;
                end
            end
            ST_RDW:  rdata   = mem_do;
            ST_ERR1: dph_err = 1'b1;
            ST_ERR2: dph_err = 1'b1;
            default: dph_err = 1'b0;
        endcase
    end

    // Transfer FSM and address-phase latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_adr   <= {ADDR_W{1'b0}};
            r_wren  <= 4'b0000;
            r_write <= 1'b0;
        end else begin
            if (w_accept) begin
                r_adr   <= haddr;
                r_wren  <= w_lane_wren;
                r_write <= hwrite;
            end else begin
                r_adr   <= r_adr;
            end
            case (r_state)
                ST_IDLE: r_state <= w_accept ? w_next_xfer : ST_IDLE;
                ST_WR: begin
                    if (!ext_busy) begin
                        r_state <= w_accept ? w_next_xfer : ST_IDLE;
                    end else begin
                        r_state <= ST_WR;
                    end
                end
                ST_RD:   r_state <= ext_busy ? ST_RD : ST_RDW;
                ST_RDW:  r_state <= w_accept ? w_next_xfer : ST_IDLE;
                ST_ERR1: r_state <= ST_ERR2;
                ST_ERR2: r_state <= w_accept ? w_next_xfer : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_h3_dbus_bridge.sv
// Directed bench for h3_dbus_bridge: a per-cycle vector table plus a
// hand-written reset-abort sequence.
module tb_h3_dbus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aph_req = 1'b0;
    logic        aph_ready;
    logic [31:0] haddr = 32'h0;
    logic [2:0]  hsize = 3'd0;
    logic        hwrite = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        dph_ready;
    logic        dph_err;
    logic [31:0] rdata;
    logic        ext_busy = 1'b0;
    logic        mem_op;
    logic [31:0] mem_adr;
    logic [3:0]  mem_wren;
    logic [31:0] mem_di;
    logic [31:0] mem_do = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    h3_dbus_bridge #(.MEM_RD_LAT(1), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .aph_req   (aph_req),
        .aph_ready (aph_ready),
        .haddr     (haddr),
        .hsize     (hsize),
        .hwrite    (hwrite),
        .wdata     (wdata),
        .dph_ready (dph_ready),
        .dph_err   (dph_err),
        .rdata     (rdata),
        .ext_busy  (ext_busy),
        .mem_op    (mem_op),
        .mem_adr   (mem_adr),
        .mem_wren  (mem_wren),
        .mem_di    (mem_di),
        .mem_do    (mem_do)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wd;
        logic        busy;
        logic [31:0] mdo;
        logic        e_aphr;
        logic        e_dphr;
        logic        e_err;
        logic        e_op;
        logic [31:0] e_adr;
        logic [3:0]  e_wren;
        logic [31:0] e_di;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic req, input logic [31:0] addr, input logic [2:0] size,
                       input logic wr, input logic [31:0] wd, input logic busy,
                       input logic [31:0] mdo, input logic e_aphr, input logic e_dphr,
                       input logic e_err, input logic e_op, input logic [31:0] e_adr,
                       input logic [3:0] e_wren, input logic [31:0] e_di,
                       input logic [31:0] e_rdata);
        vec_t v;
        v.req = req; v.addr = addr; v.size = size; v.wr = wr; v.wd = wd;
        v.busy = busy; v.mdo = mdo; v.e_aphr = e_aphr; v.e_dphr = e_dphr;
        v.e_err = e_err; v.e_op = e_op; v.e_adr = e_adr; v.e_wren = e_wren;
        v.e_di = e_di; v.e_rdata = e_rdata;
        vecs.push_back(v);
    endtask

    // Compare every DUT output against the expected set
    task automatic chk(input string name, input logic e_aphr, input logic e_dphr,
                       input logic e_err, input logic e_op, input logic [31:0] e_adr,
                       input logic [3:0] e_wren, input logic [31:0] e_di,
                       input logic [31:0] e_rdata);
        logic [103:0] act;
        logic [103:0] exp;
        act = {aph_ready, dph_ready, dph_err, mem_op, mem_adr, mem_wren, mem_di, rdata};
        exp = {e_aphr, e_dphr, e_err, e_op, e_adr, e_wren, e_di, e_rdata};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got aphr/dphr/err/op/adr/wren/di/rdata=%h, want %h",
                     name, act, exp);
        end
    endtask

    initial begin
        // req addr size wr wdata busy mem_do | aphr dphr err op adr wren di rdata
        // word write 0x10
        add(1, 32'h10, 3'd2, 1, 32'h0, 0, 32'h0,              1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'hDEADBEEF, 0, 32'h0,         0,1,0,1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
        // byte write 0x10003
        add(1, 32'h10003, 3'd0, 1, 32'h0, 0, 32'h0,           1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'hAA000000, 0, 32'h0,         0,1,0,1, 32'h10003, 4'h8, 32'hAA000000, 32'h0);
        // half write 0x10002
        add(1, 32'h10002, 3'd1, 1, 32'h0, 0, 32'h0,           1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h5555AAAA, 0, 32'h0,         0,1,0,1, 32'h10002, 4'hC, 32'h5555AAAA, 32'h0);
        // word read 0x20004
        add(1, 32'h20004, 3'd2, 0, 32'h0, 0, 32'h0,           1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h99, 0, 32'hFFFFFFFF,        0,0,0,1, 32'h20004, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h12345678,         0,1,0,0, 32'h0, 4'h0, 32'h0, 32'h12345678);
        // back-to-back: write 0x4 then read 0x0 accepted in its completing cycle
        add(1, 32'h4, 3'd2, 1, 32'h0, 0, 32'h0,               1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(1, 32'h0, 3'd2, 0, 32'h0BADF00D, 0, 32'h0,         1,1,0,1, 32'h4, 4'hF, 32'h0BADF00D, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0,               0,0,0,1, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'hCAFEF00D,         0,1,0,0, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D);
        // read 0x8 stalled 3 cycles by the debugger
        add(1, 32'h8, 3'd2, 0, 32'h0, 0, 32'h0,               1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 1, 32'hFFFFFFFF,         0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(1, 32'h30, 3'd2, 1, 32'h0, 1, 32'h0,              0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 1, 32'h0,               0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0,               0,0,0,1, 32'h8, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h11223344,         0,1,0,0, 32'h0, 4'h0, 32'h0, 32'h11223344);
        // write 0xC stalled one cycle
        add(1, 32'hC, 3'd2, 1, 32'h0, 0, 32'h0,               1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h77, 1, 32'h0,               0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h77, 0, 32'h0,               0,1,0,1, 32'hC, 4'hF, 32'h77, 32'h0);
        // ext_busy rising together with the accept
        add(1, 32'h14, 3'd2, 1, 32'h0, 1, 32'h0,              1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 1, 32'h0,               0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h01020304, 0, 32'h0,         0,1,0,1, 32'h14, 4'hF, 32'h01020304, 32'h0);
        // misaligned word read 0x2, then misaligned half accepted in ERR2
        add(1, 32'h2, 3'd2, 0, 32'h0, 0, 32'h0,               1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(1, 32'h40, 3'd2, 0, 32'h0, 0, 32'h0,              0,0,1,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(1, 32'h1, 3'd1, 0, 32'h0, 0, 32'h0,               1,1,1,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0,               0,0,1,0, 32'h0, 4'h0, 32'h0, 32'h0);
        // illegal size 3 accepted in ERR2
        add(1, 32'h0, 3'd3, 1, 32'h0, 0, 32'h0,               1,1,1,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'h0,               0,0,1,0, 32'h0, 4'h0, 32'h0, 32'h0);
        // byte write 0x21 accepted in ERR2
        add(1, 32'h21, 3'd0, 1, 32'h0, 0, 32'h0,              1,1,1,0, 32'h0, 4'h0, 32'h0, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0000BB00, 0, 32'h0,         0,1,0,1, 32'h21, 4'h2, 32'h0000BB00, 32'h0);
        add(0, 32'h0, 3'd0, 0, 32'h0, 0, 32'hFFFFFFFF,         0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);

        // reset state, with inputs trying to provoke activity
        aph_req = 1'b1; haddr = 32'h10; hsize = 3'd2; hwrite = 1'b1;
        wdata = 32'hFFFFFFFF; mem_do = 32'hFFFFFFFF;
        #3;
        chk("reset_outputs", 0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        aph_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // table-driven vectors, one row per clock
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            aph_req = vecs[i].req; haddr = vecs[i].addr; hsize = vecs[i].size;
            hwrite = vecs[i].wr; wdata = vecs[i].wd; ext_busy = vecs[i].busy;
            mem_do = vecs[i].mdo;
            #1;
            chk($sformatf("vec%0d", i), vecs[i].e_aphr, vecs[i].e_dphr, vecs[i].e_err,
                vecs[i].e_op, vecs[i].e_adr, vecs[i].e_wren, vecs[i].e_di, vecs[i].e_rdata);
        end

        // reset asserted while a read is issuing
        @(negedge clk);
        aph_req = 1'b1; haddr = 32'h100; hsize = 3'd2; hwrite = 1'b0;
        ext_busy = 1'b0; mem_do = 32'hA5A5A5A5; wdata = 32'h0;
        #1;
        chk("rst_seq_accept", 1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        aph_req = 1'b0;
        #1;
        chk("rst_seq_rd_issue", 0,0,0,1, 32'h100, 4'h0, 32'h0, 32'h0);
        #1;
        reset = 1'b1;
        aph_req = 1'b1;
        #1;
        chk("rst_seq_abort", 0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        aph_req = 1'b0;
        #1;
        chk("rst_seq_no_complete", 0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_seq_idle", 0,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        // recovery: a fresh write goes through normally
        @(negedge clk);
        aph_req = 1'b1; haddr = 32'h50; hsize = 3'd2; hwrite = 1'b1;
        #1;
        chk("post_rst_accept", 1,0,0,0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        aph_req = 1'b0; wdata = 32'h600DCAFE;
        #1;
        chk("post_rst_write", 0,1,0,1, 32'h50, 4'hF, 32'h600DCAFE, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
